// File: rtl/fetch_state_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_state_unit
// Purpose  : Architectural state of the multi-cycle datapath. Holds the
//            program counter, instruction register and memory data register,
//            drives the shared instruction/data memory address, selects the
//            next PC, counts retired fetches and flags misaligned PC loads.
// Ports    : CLK, RST          clock, asynchronous active-high reset
//            PCWE, Branch, Zero PC write enables (Branch qualified by Zero)
//            PCSel[1:0]        next-PC source (ALUResult/ALUOut/jump/hold)
//            IRWE              instruction register load strobe
//            IDSel             memory address select (0 = PC, 1 = ALUOut)
//            ALUResult, ALUOut combinational / registered ALU results
//            MemRD             unified memory read data
//            Addr              memory address (combinational)
//            PC, Instr, MDR    architectural registers
//            OPCODE, FUNCT     instruction fields for the control unit
//            FetchCount        IR loads since reset (wrapping)
//            AlignErr          sticky misaligned-PC flag
// Revision : 1.0 - initial release
// ============================================================================
module fetch_state_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWE,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [1:0]  PCSel,
    input  logic        IRWE,
    input  logic        IDSel,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemRD,
    output logic [31:0] Addr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  OPCODE,
    output logic [5:0]  FUNCT,
    output logic [31:0] MDR,
    output logic [31:0] FetchCount,
    output logic        AlignErr
);

    localparam logic [1:0] c_sel_alu_result = 2'b00;
    localparam logic [1:0] c_sel_alu_out    = 2'b01;
    localparam logic [1:0] c_sel_jump       = 2'b10;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_mdr;
    logic [31:0] r_fetch_count;
    logic        r_align_err;

    logic        w_pc_en;
    logic        w_pc_load;
    logic [31:0] w_pc_next;

    assign w_pc_en = PCWE | (Branch & Zero);

    // Jump target uses the IR as currently held, so a jump issued on the same
    // edge as an IR load still targets the previous instruction's field.
    always_comb begin
        w_pc_next = r_pc;
        w_pc_load = 1'b0;
        case (PCSel)
            c_sel_alu_result: begin
                w_pc_next = ALUResult;
                w_pc_load = w_pc_en;
            end
            c_sel_alu_out: begin
                w_pc_next = ALUOut;
                w_pc_load = w_pc_en;
            end
            c_sel_jump: begin
                w_pc_next = {r_pc[31:28], r_instr[25:0], 2'b00};
                w_pc_load = w_pc_en;
            end
            default: begin
                // Reserved select: the PC holds regardless of the enables.
                w_pc_next = r_pc;
                w_pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_mdr         <= 32'h0000_0000;
            r_fetch_count <= 32'h0000_0000;
            r_align_err   <= 1'b0;
        end else begin
            r_mdr <= MemRD;
            if (w_pc_load) begin
                r_pc <= w_pc_next;
                // Misaligned targets are still loaded; only the flag records it.
                if (w_pc_next[1:0] != 2'b00) begin
                    r_align_err <= 1'b1;
                end
            end
            if (IRWE) begin
                r_instr       <= MemRD;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign Addr       = IDSel ? ALUOut : r_pc;
    assign PC         = r_pc;
    assign Instr      = r_instr;
    assign OPCODE     = r_instr[31:26];
    assign FUNCT      = r_instr[5:0];
    assign MDR        = r_mdr;
    assign FetchCount = r_fetch_count;
    assign AlignErr   = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_state_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_state_unit
// Purpose  : Self-checking bench for fetch_state_unit: directed vector table,
//            hand-written reset / wrap sequences and a randomized run checked
//            against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_state_unit;

    logic        CLK;
    logic        RST;
    logic        PCWE;
    logic        Branch;
    logic        Zero;
    logic [1:0]  PCSel;
    logic        IRWE;
    logic        IDSel;
    logic [31:0] ALUResult;
    logic [31:0] ALUOut;
    logic [31:0] MemRD;
    logic [31:0] Addr;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [5:0]  OPCODE;
    logic [5:0]  FUNCT;
    logic [31:0] MDR;
    logic [31:0] FetchCount;
    logic        AlignErr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_state_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PCWE(PCWE), .Branch(Branch), .Zero(Zero),
        .PCSel(PCSel), .IRWE(IRWE), .IDSel(IDSel), .ALUResult(ALUResult),
        .ALUOut(ALUOut), .MemRD(MemRD), .Addr(Addr), .PC(PC), .Instr(Instr),
        .OPCODE(OPCODE), .FUNCT(FUNCT), .MDR(MDR), .FetchCount(FetchCount),
        .AlignErr(AlignErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        pcwe;
        logic        branch;
        logic        zero;
        logic [1:0]  pcsel;
        logic        irwe;
        logic        idsel;
        logic [31:0] alu_result;
        logic [31:0] alu_out;
        logic [31:0] memrd;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_mdr;
        logic [31:0] exp_cnt;
        logic        exp_aerr;
    } vec_t;

    vec_t vec[12];

    function automatic vec_t mk(logic pcwe, logic branch, logic zero, logic [1:0] pcsel,
                                logic irwe, logic idsel, logic [31:0] alu_result,
                                logic [31:0] alu_out, logic [31:0] memrd,
                                logic [31:0] exp_addr, logic [31:0] exp_pc,
                                logic [31:0] exp_instr, logic [31:0] exp_mdr,
                                logic [31:0] exp_cnt, logic exp_aerr);
        vec_t v;
        v.pcwe = pcwe; v.branch = branch; v.zero = zero; v.pcsel = pcsel;
        v.irwe = irwe; v.idsel = idsel; v.alu_result = alu_result;
        v.alu_out = alu_out; v.memrd = memrd; v.exp_addr = exp_addr;
        v.exp_pc = exp_pc; v.exp_instr = exp_instr; v.exp_mdr = exp_mdr;
        v.exp_cnt = exp_cnt; v.exp_aerr = exp_aerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pcwe, input logic branch, input logic zero,
                         input logic [1:0] pcsel, input logic irwe, input logic idsel,
                         input logic [31:0] alu_result, input logic [31:0] alu_out,
                         input logic [31:0] memrd);
        PCWE = pcwe; Branch = branch; Zero = zero; PCSel = pcsel; IRWE = irwe;
        IDSel = idsel; ALUResult = alu_result; ALUOut = alu_out; MemRD = memrd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] mdr, input logic [31:0] cnt, input logic aerr);
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".Instr"}, Instr, instr);
        chk({tag, ".OPCODE"}, {26'h0, OPCODE}, {26'h0, instr[31:26]});
        chk({tag, ".FUNCT"}, {26'h0, FUNCT}, {26'h0, instr[5:0]});
        chk({tag, ".MDR"}, MDR, mdr);
        chk({tag, ".FetchCount"}, FetchCount, cnt);
        chk({tag, ".AlignErr"}, {31'h0, AlignErr}, {31'h0, aerr});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        idle();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Behavioural reference state for the randomized run.
    logic [31:0] m_pc, m_ir, m_mdr, m_cnt;
    logic        m_aerr;

    initial begin
        RST = 1'b1;
        idle();
        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.Addr", Addr, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // ---------------- directed vector table ----------------
        //            pcwe br  z  sel  irwe ids  alures        aluout       memrd         addr          pc            instr         mdr           cnt  aerr
        vec[0]  = mk(1, 0, 0, 2'd0, 1, 0, 32'h4,        32'h0,       32'h0123_4820, 32'h0,        32'h4,        32'h0123_4820, 32'h0123_4820, 1, 0);
        vec[1]  = mk(0, 1, 0, 2'd1, 0, 0, 32'h0,        32'h80,      32'h0,         32'h4,        32'h4,        32'h0123_4820, 32'h0,         1, 0);
        vec[2]  = mk(0, 1, 1, 2'd1, 0, 0, 32'h0,        32'h80,      32'h0,         32'h4,        32'h80,       32'h0123_4820, 32'h0,         1, 0);
        vec[3]  = mk(0, 0, 0, 2'd0, 1, 0, 32'h0,        32'h0,       32'h0800_0040, 32'h80,       32'h80,       32'h0800_0040, 32'h0800_0040, 2, 0);
        vec[4]  = mk(1, 0, 0, 2'd0, 0, 0, 32'h1000_0010, 32'h0,      32'h0,         32'h80,       32'h1000_0010, 32'h0800_0040, 32'h0,        2, 0);
        vec[5]  = mk(1, 0, 0, 2'd2, 0, 0, 32'h0,        32'h0,       32'h0,         32'h1000_0010, 32'h1000_0100, 32'h0800_0040, 32'h0,       2, 0);
        vec[6]  = mk(1, 0, 0, 2'd3, 0, 0, 32'h999,      32'h777,     32'h0,         32'h1000_0100, 32'h1000_0100, 32'h0800_0040, 32'h0,       2, 0);
        vec[7]  = mk(0, 0, 0, 2'd0, 0, 1, 32'h0,        32'h2C,      32'hDEAD_BEEF, 32'h2C,       32'h1000_0100, 32'h0800_0040, 32'hDEAD_BEEF, 2, 0);
        vec[8]  = mk(1, 0, 0, 2'd0, 0, 0, 32'h6,        32'h0,       32'h0,         32'h1000_0100, 32'h6,        32'h0800_0040, 32'h0,         2, 1);
        vec[9]  = mk(1, 0, 0, 2'd0, 0, 0, 32'h8,        32'h0,       32'h0,         32'h6,        32'h8,        32'h0800_0040, 32'h0,         2, 1);
        vec[10] = mk(1, 0, 0, 2'd2, 1, 0, 32'h0,        32'h0,       32'h0800_0003, 32'h8,        32'h100,      32'h0800_0003, 32'h0800_0003, 3, 1);
        vec[11] = mk(0, 1, 0, 2'd1, 0, 0, 32'h0,        32'h3,       32'h5,         32'h100,      32'h100,      32'h0800_0003, 32'h5,         3, 1);

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].pcwe, vec[i].branch, vec[i].zero, vec[i].pcsel, vec[i].irwe,
                  vec[i].idsel, vec[i].alu_result, vec[i].alu_out, vec[i].memrd);
            #1;
            chk($sformatf("vec%0d.Addr", i), Addr, vec[i].exp_addr);
            @(negedge CLK);
            check_state($sformatf("vec%0d", i), vec[i].exp_pc, vec[i].exp_instr,
                        vec[i].exp_mdr, vec[i].exp_cnt, vec[i].exp_aerr);
        end

        // ---------------- mid-run asynchronous reset ----------------
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i == 6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_0000 + i);
            @(negedge CLK);
        end
        idle();
        chk("prereset.PC", PC, 32'h40);
        chk("prereset.FetchCount", FetchCount, 32'd7);
        #2;
        RST = 1'b1;
        #1;
        check_state("async_reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("async_reset.Addr", Addr, 32'h0);
        // Enables asserted while reset is held must have no effect.
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h44, 32'h0, 32'hABCD_0000);
        @(negedge CLK);
        check_state("held_reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        RST = 1'b0;
        // First edge after release performs the update.
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h44, 32'h0, 32'hABCD_0001);
        @(negedge CLK);
        check_state("post_reset", 32'h44, 32'hABCD_0001, 32'hABCD_0001, 32'd1, 1'b0);

        // ---------------- FetchCount wrap ----------------
        idle();
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_count;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0007);
        @(negedge CLK);
        chk("wrap.FetchCount", FetchCount, 32'h0);
        chk("wrap.Instr", Instr, 32'h0000_0007);

        // ---------------- randomized run vs. behavioural model ----------------
        do_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_cnt = 32'h0; m_aerr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        pcwe, branch, zero, irwe, idsel, take;
            logic [1:0]  sel;
            logic [31:0] ares, aout, mrd, target;
            pcwe   = ($urandom_range(0, 2) == 0);
            branch = $urandom_range(0, 1);
            zero   = $urandom_range(0, 1);
            sel    = 2'($urandom_range(0, 3));
            irwe   = $urandom_range(0, 1);
            idsel  = $urandom_range(0, 1);
            ares   = $urandom;
            aout   = $urandom;
            mrd    = $urandom;
            if ($urandom_range(0, 7) != 0) ares[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) aout[1:0] = 2'b00;
            drive(pcwe, branch, zero, sel, irwe, idsel, ares, aout, mrd);
            #1;
            chk("rand.Addr", Addr, idsel ? aout : m_pc);

            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                #1;
                m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_cnt = 32'h0; m_aerr = 1'b0;
                check_state("rand_reset", m_pc, m_ir, m_mdr, m_cnt, m_aerr);
                @(negedge CLK);
                RST = 1'b0;
                continue;
            end

            // Reference update from the architectural rules.
            take = (pcwe || (branch && zero)) && (sel != 2'd3);
            case (sel)
                2'd0:    target = ares;
                2'd1:    target = aout;
                default: target = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            endcase
            if (take) begin
                m_pc = target;
                if ((target % 4) != 0) m_aerr = 1'b1;
            end
            if (irwe) begin
                m_ir  = mrd;
                m_cnt = m_cnt + 1;
            end
            m_mdr = mrd;

            @(negedge CLK);
            check_state("rand", m_pc, m_ir, m_mdr, m_cnt, m_aerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
